// File: rtl/cpu_alu16_seq.sv
// Two-phase 16-bit arithmetic sequencer driving an 8-bit ALU: low byte, then high byte with chained carry.
// Optional INC16/DEC16 support is enabled by defining CPU_ALU16_INCDEC_EN.
module cpu_alu16_seq #(
    parameter logic [7:0] OPC_ADD    = 8'h80,
    parameter logic [7:0] OPC_ADD_CI = 8'h88,
    parameter logic [7:0] OPC_SUB    = 8'h90,
    parameter logic [7:0] OPC_SUB_CI = 8'h98
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op16,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [7:0]  flags_in,
    output logic [7:0]  alu_op_a,
    output logic [7:0]  alu_op_b,
    output logic [7:0]  alu_opcode,
    output logic        alu_carry_in,
    input  logic [7:0]  alu_res,
    input  logic [7:0]  alu_flags,
    output logic [15:0] res16,
    output logic [7:0]  flags_out,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_ADD16 = 3'b000;
    localparam logic [2:0] OP_ADC16 = 3'b001;
    localparam logic [2:0] OP_SBC16 = 3'b010;
    localparam logic [2:0] OP_SUB16 = 3'b011;
    localparam logic [2:0] OP_INC16 = 3'b100;
    localparam logic [2:0] OP_DEC16 = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [7:0]  a_hi;
    logic [7:0]  b_hi;
    logic [7:0]  fl_q;
    logic [7:0]  res_lo;
    logic        z_lo;

    logic        op_valid;
    logic [15:0] b_eff;
    logic [7:0]  flag_mask;
    logic [7:0]  comb_flags;

    function automatic logic is_sub_op(input logic [2:0] op);
        return (op == OP_SBC16) || (op == OP_SUB16) || (op == OP_DEC16);
    endfunction

    function automatic logic uses_carry(input logic [2:0] op);
        return (op == OP_ADC16) || (op == OP_SBC16);
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        op_valid = 1'b0;
        b_eff    = op_b;
        case (op16)
            OP_ADD16, OP_ADC16, OP_SBC16, OP_SUB16: op_valid = 1'b1;
`ifdef CPU_ALU16_INCDEC_EN
            OP_INC16, OP_DEC16: begin
                op_valid = 1'b1;
                b_eff    = 16'h0001;
            end
`endif
            default: op_valid = 1'b0;
        endcase
    end

    // Mask selects which bits come from the high ALU pass; the rest come from the latched flags.
    always_comb begin
        flag_mask  = 8'b1001_0111;
        comb_flags = 8'h00;
        case (op_q)
            OP_ADD16:           flag_mask = 8'b0001_0011;
            OP_INC16, OP_DEC16: flag_mask = 8'b0000_0000;
            default:            flag_mask = 8'b1001_0111;
        endcase
        comb_flags = (alu_flags & flag_mask) | (fl_q & ~flag_mask);
        if ((op_q == OP_ADC16) || (op_q == OP_SBC16) || (op_q == OP_SUB16))
            comb_flags[6] = z_lo & alu_flags[6];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= 3'b000;
            a_hi         <= 8'h00;
            b_hi         <= 8'h00;
            fl_q         <= 8'h00;
            res_lo       <= 8'h00;
            z_lo         <= 1'b0;
            alu_op_a     <= 8'h00;
            alu_op_b     <= 8'h00;
            alu_opcode   <= 8'h00;
            alu_carry_in <= 1'b0;
            res16        <= 16'h0000;
            flags_out    <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start && op_valid) begin
                        op_q         <= op16;
                        a_hi         <= op_a[15:8];
                        b_hi         <= b_eff[15:8];
                        fl_q         <= flags_in;
                        alu_op_a     <= op_a[7:0];
                        alu_op_b     <= b_eff[7:0];
                        alu_carry_in <= uses_carry(op16) & flags_in[0];
                        if (is_sub_op(op16))
                            alu_opcode <= uses_carry(op16) ? OPC_SUB_CI : OPC_SUB;
                        else
                            alu_opcode <= uses_carry(op16) ? OPC_ADD_CI : OPC_ADD;
                        busy         <= 1'b1;
                        state        <= S_LOW;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOW: begin
                    res_lo       <= alu_res;
                    z_lo         <= alu_flags[6];
                    alu_op_a     <= a_hi;
                    alu_op_b     <= b_hi;
                    alu_opcode   <= is_sub_op(op_q) ? OPC_SUB_CI : OPC_ADD_CI;
                    alu_carry_in <= alu_flags[0];
                    state        <= S_HIGH;
                end
                S_HIGH: begin
                    res16        <= {alu_res, res_lo};
                    flags_out    <= comb_flags;
                    alu_op_a     <= 8'h00;
                    alu_op_b     <= 8'h00;
                    alu_opcode   <= 8'h00;
                    alu_carry_in <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_alu16_seq.sv
// Bench for cpu_alu16_seq: pairs the sequencer with a behavioural Z80 8-bit ALU and checks
// results against a whole-word 16-bit arithmetic model.
module tb_cpu_alu16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op16;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [7:0]  flags_in;
    logic [7:0]  alu_op_a;
    logic [7:0]  alu_op_b;
    logic [7:0]  alu_opcode;
    logic        alu_carry_in;
    logic [7:0]  alu_res;
    logic [7:0]  alu_flags;
    logic [15:0] res16;
    logic [7:0]  flags_out;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_res;
    logic [7:0]  exp_fl;

    cpu_alu16_seq dut (
        .clk(clk), .reset(reset), .start(start), .op16(op16), .op_a(op_a), .op_b(op_b),
        .flags_in(flags_in), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_opcode(alu_opcode),
        .alu_carry_in(alu_carry_in), .alu_res(alu_res), .alu_flags(alu_flags), .res16(res16),
        .flags_out(flags_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural Z80 8-bit ALU (add/adc/sub/sbc)
    logic [8:0] s9;
    logic [4:0] s5;
    logic       cin8;
    always_comb begin
        s9        = 9'h000;
        s5        = 5'h00;
        cin8      = 1'b0;
        alu_res   = 8'h00;
        alu_flags = 8'h00;
        if (alu_opcode == 8'h88 || alu_opcode == 8'h98) cin8 = alu_carry_in;
        if (alu_opcode == 8'h80 || alu_opcode == 8'h88) begin
            s9 = {1'b0, alu_op_a} + {1'b0, alu_op_b} + {8'h00, cin8};
            s5 = {1'b0, alu_op_a[3:0]} + {1'b0, alu_op_b[3:0]} + {4'h0, cin8};
            alu_res = s9[7:0];
            alu_flags = {s9[7], s9[7:0] == 8'h00, s9[5], s5[4], s9[3],
                         (alu_op_a[7] == alu_op_b[7]) && (s9[7] != alu_op_a[7]), 1'b0, s9[8]};
        end else if (alu_opcode == 8'h90 || alu_opcode == 8'h98) begin
            s9 = {1'b0, alu_op_a} - {1'b0, alu_op_b} - {8'h00, cin8};
            s5 = {1'b0, alu_op_a[3:0]} - {1'b0, alu_op_b[3:0]} - {4'h0, cin8};
            alu_res = s9[7:0];
            alu_flags = {s9[7], s9[7:0] == 8'h00, s9[5], s5[4], s9[3],
                         (alu_op_a[7] != alu_op_b[7]) && (s9[7] != alu_op_a[7]), 1'b1, s9[8]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-word 16-bit reference: flags derived from full-width carries and overflow
    task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b_in,
                         input logic [7:0] fl, output logic [15:0] r, output logic [7:0] f);
        logic [15:0] b;
        int          cin, full, half;
        logic        c, h, v, sub;
        b   = b_in;
        if (op == 3'd4 || op == 3'd5) b = 16'h0001;
        sub = (op == 3'd2 || op == 3'd3 || op == 3'd5);
        cin = (op == 3'd1 || op == 3'd2) ? int'(fl[0]) : 0;
        if (!sub) begin
            full = int'(a) + int'(b) + cin;
            half = int'(a & 16'h0FFF) + int'(b & 16'h0FFF) + cin;
            c = full > 32'sh0000_FFFF;
            h = half > 32'sh0000_0FFF;
        end else begin
            full = int'(a) - int'(b) - cin;
            half = int'(a & 16'h0FFF) - int'(b & 16'h0FFF) - cin;
            c = full < 0;
            h = half < 0;
        end
        r = full[15:0];
        v = sub ? ((a[15] != b[15]) && (r[15] != a[15])) : ((a[15] == b[15]) && (r[15] != a[15]));
        case (op)
            3'd0:       f = {fl[7], fl[6], fl[5], h, fl[3], fl[2], 1'b0, c};
            3'd4, 3'd5: f = fl;
            default:    f = {r[15], r == 16'h0000, fl[5], h, fl[3], v, sub, c};
        endcase
    endtask

    // Called at a negedge; returns at the next negedge with inputs scrambled.
    task automatic launch(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] fl);
        op16 = op; op_a = a; op_b = b; flags_in = fl; start = 1'b1;
        model(op, a, b, fl, exp_res, exp_fl);
        @(negedge clk);
        start = 1'b0; op16 = 3'($urandom); op_a = 16'($urandom);
        op_b = 16'($urandom); flags_in = 8'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 1;
        check({tag, " busy_low"}, busy, 1'b1);
        while (done !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 3);
        check({tag, " busy_in_done"}, busy, 1'b0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] r, input logic [7:0] f);
        check({tag, " res16"}, res16, r);
        check({tag, " flags"}, flags_out, f);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [7:0] fl);
        launch(op, a, b, fl);
        wait_done(tag);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 1'b0);
        check_result(tag, exp_res, exp_fl);
    endtask

    task automatic expect_ignored(input string tag, input logic [2:0] op);
        int seen;
        logic [15:0] prev;
        prev = res16;
        seen = 0;
        op16 = op; op_a = 16'h1234; op_b = 16'h1111; flags_in = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            if (busy === 1'b1 || done === 1'b1) seen++;
            @(negedge clk);
        end
        check({tag, " no_activity"}, seen, 0);
        check({tag, " res_held"}, res16, prev);
    endtask

    initial begin
        logic [15:0] keep_r;
        logic [7:0]  keep_f;
        reset = 1'b1; start = 1'b0; op16 = 3'd0; op_a = 16'h0; op_b = 16'h0; flags_in = 8'h0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset res16", res16, 16'h0000);
        check("reset flags", flags_out, 8'h00);
        check("reset alu_opcode", alu_opcode, 8'h00);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op("add16", 3'd0, 16'h1234, 16'h0FCD, 8'hC4);
        check("add16 literal res", res16, 16'h2201);
        check("add16 literal flags", flags_out, 8'hD4);
        run_op("adc16", 3'd1, 16'hFFFF, 16'h0000, 8'h01);
        check("adc16 literal flags", flags_out, 8'h51);
        run_op("sbc16", 3'd2, 16'h8000, 16'h0001, 8'h00);
        check("sbc16 literal res", res16, 16'h7FFF);
        run_op("sub16 zero", 3'd3, 16'h0100, 16'h0100, 8'h00);
        check("sub16 zero Z", flags_out[6], 1'b1);
        run_op("sub16 lowzero", 3'd3, 16'h0100, 16'h0000, 8'h40);
        check("sub16 lowzero Z", flags_out[6], 1'b0);
        run_op("sbc16 borrow", 3'd2, 16'h0000, 16'h0000, 8'h29);
        run_op("adc16 ovf", 3'd1, 16'h7FFF, 16'h0000, 8'h01);

        // Reset while in HIGH aborts at once
        launch(3'd0, 16'h4321, 16'h1111, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort res16", res16, 16'h0000);
        check("abort alu_op_a", alu_op_a, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        expect_ignored("after abort", 3'd6);

        // Start while busy is ignored
        launch(3'd3, 16'h5000, 16'h1000, 8'h00);
        op16 = 3'd0; op_a = 16'h0001; op_b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy start busy_high", busy, 1'b1);
        @(negedge clk);
        check("busy start done", done, 1'b1);
        @(negedge clk);
        check("busy start no_queue", busy, 1'b0);
        check_result("busy start", exp_res, exp_fl);

        // Back-to-back start in DONE
        launch(3'd0, 16'hAAAA, 16'h5556, 8'h80);
        wait_done("b2b first");
        keep_r = exp_res; keep_f = exp_fl;
        launch(3'd1, 16'h00FF, 16'h0F01, 8'h01);
        check("b2b accepted", busy, 1'b1);
        check_result("b2b first", keep_r, keep_f);
        wait_done("b2b second");
        @(negedge clk);
        check_result("b2b second", exp_res, exp_fl);

        expect_ignored("undef 110", 3'd6);
        expect_ignored("undef 111", 3'd7);
`ifdef CPU_ALU16_INCDEC_EN
        run_op("inc16 wrap", 3'd4, 16'hFFFF, 16'h1234, 8'h00);
        check("inc16 literal res", res16, 16'h0000);
        check("inc16 literal flags", flags_out, 8'h00);
        run_op("dec16 wrap", 3'd5, 16'h0000, 16'h5555, 8'hA5);
`else
        expect_ignored("undef 100", 3'd4);
        expect_ignored("undef 101", 3'd5);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef CPU_ALU16_INCDEC_EN
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 5)), 16'($urandom),
                   16'($urandom), 8'($urandom));
`else
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 3)), 16'($urandom),
                   16'($urandom), 8'($urandom));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
